// File: rtl/sst_engine.sv
`default_nettype none
// ============================================================================
//  Module   : sst_engine
//  Purpose  : Save-state initiator. Walks mapper registers over the SST bus,
//             saving them to a buffer RAM or restoring them after an ID check.
//  Revision : 1.0 - initial release
// ============================================================================
module sst_engine #(
    parameter int REG_COUNT  = 128,
    parameter int BUF_BASE   = 0,
    parameter int RD_SETTLE  = 2,
    parameter int M2_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_save,
    input  logic        start_load,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic        m2,
    output logic        sst_act,
    output logic        sst_we_reg,
    output logic [7:0]  sst_addr,
    output logic [7:0]  sst_dato,
    input  logic [7:0]  sst_di,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_dout,
    output logic        mem_we,
    input  logic [7:0]  mem_din
);

    localparam logic [3:0] c_st_idle       = 4'd0;
    localparam logic [3:0] c_st_sv_set     = 4'd1;
    localparam logic [3:0] c_st_sv_wait    = 4'd2;
    localparam logic [3:0] c_st_sv_store   = 4'd3;
    localparam logic [3:0] c_st_ld_chk_set = 4'd4;
    localparam logic [3:0] c_st_ld_chk_cmp = 4'd5;
    localparam logic [3:0] c_st_ld_rd      = 4'd6;
    localparam logic [3:0] c_st_ld_wr      = 4'd7;
    localparam logic [3:0] c_st_ld_m2      = 4'd8;
    localparam logic [3:0] c_st_fin        = 4'd9;

    localparam int c_chk_wait = (RD_SETTLE > 1) ? RD_SETTLE : 1;
    localparam int c_sw       = $clog2(c_chk_wait + 1);
    localparam int c_tw       = $clog2(M2_TIMEOUT + 1);
    localparam logic [c_sw-1:0] c_sv_last  = c_sw'((RD_SETTLE > 0) ? RD_SETTLE - 1 : 0);
    localparam logic [c_sw-1:0] c_chk_last = c_sw'(c_chk_wait - 1);
    localparam logic [c_tw-1:0] c_tmo_last = c_tw'(M2_TIMEOUT - 1);
    localparam logic [7:0]      c_id_idx   = 8'(REG_COUNT - 1);
    localparam logic [7:0]      c_last_wr  = 8'(REG_COUNT - 2);
    localparam logic [15:0]     c_base     = 16'(BUF_BASE);

    logic [3:0]      r_state;
    logic [3:0]      w_next;
    logic [7:0]      r_idx;
    logic [c_sw-1:0] r_settle;
    logic [c_tw-1:0] r_tmo;
    logic            r_err;
    logic            r_m2_s1;
    logic            r_m2_sync;
    logic            r_m2_prev;
    logic [7:0]      r_addr_hold;
    logic [7:0]      r_dato_hold;

    logic            w_busy;
    logic            w_done;
    logic            w_mem_we;
    logic            w_we_reg;
    logic [7:0]      w_sst_addr;
    logic [7:0]      w_sst_dato;
    logic [15:0]     w_mem_addr;
    logic [7:0]      w_mem_dout;

    logic w_start;
    logic w_sv_settled;
    logic w_chk_settled;
    logic w_m2_fall;
    logic w_fall_ok;

    assign w_start       = start_save | start_load;
    assign w_sv_settled  = (r_settle == c_sv_last);
    assign w_chk_settled = (r_settle == c_chk_last);
    assign w_m2_fall     = r_m2_prev & ~r_m2_sync;
    // The first LD_M2 cycle carries a fall that began before the strobe rose.
    assign w_fall_ok     = w_m2_fall && (r_tmo != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (start_save) begin
                    w_next = c_st_sv_set;
                end else if (start_load) begin
                    w_next = c_st_ld_chk_set;
                end
            end
            c_st_sv_set:     w_next = (RD_SETTLE > 0) ? c_st_sv_wait : c_st_sv_store;
            c_st_sv_wait:    if (w_sv_settled) w_next = c_st_sv_store;
            c_st_sv_store:   w_next = (r_idx == c_id_idx) ? c_st_fin : c_st_sv_set;
            c_st_ld_chk_set: if (w_chk_settled) w_next = c_st_ld_chk_cmp;
            c_st_ld_chk_cmp: begin
                if ((mem_din != sst_di) || (REG_COUNT < 2)) begin
                    w_next = c_st_fin;
                end else begin
                    w_next = c_st_ld_rd;
                end
            end
            c_st_ld_rd:      w_next = c_st_ld_wr;
            c_st_ld_wr:      w_next = c_st_ld_m2;
            c_st_ld_m2: begin
                if (w_fall_ok) begin
                    w_next = (r_idx == c_last_wr) ? c_st_fin : c_st_ld_rd;
                end else if (r_tmo == c_tmo_last) begin
                    w_next = c_st_fin;
                end
            end
            c_st_fin:        w_next = c_st_idle;
            default:         w_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_settle    <= '0;
            r_tmo       <= '0;
            r_err       <= 1'b0;
            r_m2_s1     <= 1'b0;
            r_m2_sync   <= 1'b0;
            r_m2_prev   <= 1'b0;
            r_addr_hold <= '0;
            r_dato_hold <= '0;
        end else begin
            r_m2_s1   <= m2;
            r_m2_sync <= r_m2_s1;
            r_m2_prev <= r_m2_sync;

            if ((r_state == c_st_sv_wait && !w_sv_settled) ||
                (r_state == c_st_ld_chk_set && !w_chk_settled)) begin
                r_settle <= r_settle + c_sw'(1);
            end else begin
                r_settle <= '0;
            end

            if (r_state == c_st_ld_m2 && w_next == c_st_ld_m2) begin
                r_tmo <= r_tmo + c_tw'(1);
            end else begin
                r_tmo <= '0;
            end

            if (r_state != c_st_idle) begin
                r_addr_hold <= w_sst_addr;
            end

            case (r_state)
                c_st_idle: begin
                    if (w_start) begin
                        r_idx <= '0;
                        r_err <= 1'b0;
                    end
                end
                c_st_sv_store: begin
                    if (r_idx != c_id_idx) begin
                        r_idx <= r_idx + 8'd1;
                    end
                end
                c_st_ld_chk_cmp: begin
                    r_idx <= '0;
                    if (mem_din != sst_di) begin
                        r_err <= 1'b1;
                    end
                end
                c_st_ld_wr: r_dato_hold <= mem_din;
                c_st_ld_m2: begin
                    if (w_fall_ok) begin
                        r_idx <= r_idx + 8'd1;
                    end else if (r_tmo == c_tmo_last) begin
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_busy     = (r_state != c_st_idle);
        w_done     = (r_state == c_st_fin);
        w_mem_we   = (r_state == c_st_sv_store);
        w_we_reg   = (r_state == c_st_ld_wr) || (r_state == c_st_ld_m2);
        w_sst_addr = r_addr_hold;
        w_sst_dato = r_dato_hold;
        w_mem_addr = '0;
        w_mem_dout = '0;
        case (r_state)
            c_st_sv_set, c_st_sv_wait: begin
                w_sst_addr = r_idx;
                w_mem_addr = c_base + {8'd0, r_idx};
            end
            c_st_sv_store: begin
                w_sst_addr = r_idx;
                w_mem_addr = c_base + {8'd0, r_idx};
                w_mem_dout = sst_di;
            end
            c_st_ld_chk_set, c_st_ld_chk_cmp: begin
                w_sst_addr = c_id_idx;
                w_mem_addr = c_base + {8'd0, c_id_idx};
            end
            c_st_ld_rd: w_mem_addr = c_base + {8'd0, r_idx};
            c_st_ld_wr: begin
                w_sst_addr = r_idx;
                w_sst_dato = mem_din;
                w_mem_addr = c_base + {8'd0, r_idx};
            end
            c_st_ld_m2: begin
                w_sst_addr = r_idx;
                w_mem_addr = c_base + {8'd0, r_idx};
            end
            default: ;
        endcase
    end

    assign busy       = w_busy;
    assign sst_act    = w_busy;
    assign done       = w_done;
    assign err        = r_err;
    assign sst_we_reg = w_we_reg;
    assign sst_addr   = w_sst_addr;
    assign sst_dato   = w_sst_dato;
    assign mem_addr   = w_mem_addr;
    assign mem_dout   = w_mem_dout;
    assign mem_we     = w_mem_we;

endmodule
`default_nettype wire

// File: tb/tb_sst_engine.sv
`default_nettype none
// Bench for sst_engine: mapper register file, save-buffer RAM and free-running m2
// models, with expected images computed from snapshots of random register data.
module tb_sst_engine;

    localparam int BUF_BASE = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_save;
    logic        start_load;
    logic        busy, done, err, sst_act, sst_we_reg, mem_we;
    logic        m2;
    logic [7:0]  sst_addr, sst_dato, sst_di, mem_dout, mem_din;
    logic [15:0] mem_addr;

    logic [7:0]  mapper_regs [0:255];
    logic [7:0]  buffer [0:65535];
    int          wr_cnt [0:255];
    logic [7:0]  exp_img [0:255];
    bit          m2_run;
    longint      last_fall;

    int n_vec = 0;
    int n_err = 0;

    int     st_cycles, st_mem_we, st_we_pulses, st_we_hi, st_bad, st_lat_bad;
    bit     st_done, st_err_at_done, st_we_at_done;
    logic [7:0] st_addr_at_done;
    logic [4:0] st_post;

    sst_engine #(
        .REG_COUNT (128),
        .BUF_BASE  (BUF_BASE),
        .RD_SETTLE (2),
        .M2_TIMEOUT(1024)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_save(start_save),
        .start_load(start_load),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .m2        (m2),
        .sst_act   (sst_act),
        .sst_we_reg(sst_we_reg),
        .sst_addr  (sst_addr),
        .sst_dato  (sst_dato),
        .sst_di    (sst_di),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .mem_we    (mem_we),
        .mem_din   (mem_din)
    );

    always #5 clk = ~clk;

    // m2 edges land on times ending in 2; clk edges end in 5, samples in 6.
    initial begin
        m2 = 1'b1;
        #2;
        forever begin
            #60;
            if (m2_run) m2 = ~m2;
        end
    end

    assign sst_di = mapper_regs[sst_addr];

    always @(negedge m2) begin
        last_fall = $time;
        if (sst_we_reg === 1'b1) begin
            mapper_regs[sst_addr] = sst_dato;
            wr_cnt[sst_addr] = wr_cnt[sst_addr] + 1;
        end
    end

    always @(posedge clk) begin
        mem_din <= buffer[mem_addr];
        if (mem_we === 1'b1) buffer[mem_addr] = mem_dout;
    end

    task automatic kick(input bit s, input bit l);
        start_save = s;
        start_load = l;
        @(posedge clk); #1;
        start_save = 1'b0;
        start_load = 1'b0;
    endtask

    task automatic run_op(input int budget, input int inject_at);
        bit     prev_we;
        longint t_rise, t_drop;
        st_cycles = 0; st_mem_we = 0; st_we_pulses = 0; st_we_hi = 0;
        st_bad = 0; st_lat_bad = 0; st_done = 0; st_err_at_done = 0;
        st_we_at_done = 0; st_addr_at_done = 8'hxx; st_post = 5'h1f;
        prev_we = 1'b0; t_rise = 0;
        for (int c = 0; c <= budget; c++) begin
            if (sst_we_reg && !prev_we) begin
                st_we_pulses++;
                t_rise = $time - 1;
            end
            if (!sst_we_reg && prev_we) begin
                t_drop = $time - 1;
                if (!(last_fall > t_rise && (t_drop - last_fall) > 20 && (t_drop - last_fall) < 30))
                    st_lat_bad++;
            end
            if (sst_we_reg) st_we_hi++;
            if (mem_we) st_mem_we++;
            if (busy !== sst_act || busy !== 1'b1) st_bad++;
            prev_we = sst_we_reg;
            if (done === 1'b1) begin
                st_done = 1;
                st_cycles = c;
                st_err_at_done = err;
                st_we_at_done = sst_we_reg;
                st_addr_at_done = sst_addr;
                break;
            end
            if (c == inject_at) start_load = 1'b1;
            @(posedge clk); #1;
            start_load = 1'b0;
        end
        if (st_done) begin
            @(posedge clk); #1;
            st_post = {done, busy, sst_act, sst_we_reg, mem_we};
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_save = 1'b0; start_load = 1'b0; m2_run = 1'b0;
        for (int i = 0; i < 256; i++) begin mapper_regs[i] = 8'h00; wr_cnt[i] = 0; end
        for (int i = 0; i < 256; i++) buffer[BUF_BASE + i] = 8'h00;
        repeat (3) @(posedge clk); #1;
        n_vec++; if ({busy, done, err, sst_act, sst_we_reg, mem_we} !== 6'b0) begin n_err++;
            $display("FAIL reset_flags: got %b expected 000000", {busy, done, err, sst_act, sst_we_reg, mem_we}); end
        n_vec++; if (sst_addr !== 8'h00) begin n_err++; $display("FAIL reset_sst_addr: got %0h expected 0", sst_addr); end
        n_vec++; if (sst_dato !== 8'h00) begin n_err++; $display("FAIL reset_sst_dato: got %0h expected 0", sst_dato); end
        n_vec++; if (mem_addr !== 16'h0) begin n_err++; $display("FAIL reset_mem_addr: got %0h expected 0", mem_addr); end
        n_vec++; if (mem_dout !== 8'h00) begin n_err++; $display("FAIL reset_mem_dout: got %0h expected 0", mem_dout); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_after_reset: busy got %b expected 0", busy); end
    endtask

    task automatic test_save();
        int bad;
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < 128; i++) begin
                mapper_regs[i] = (it == 0) ? (8'(i) ^ 8'h5A) : 8'($urandom);
                buffer[BUF_BASE + i] = 8'hFF;
            end
            if (it == 0) mapper_regs[127] = 8'd87;
            for (int i = 0; i < 128; i++) exp_img[i] = mapper_regs[i];
            kick(1'b1, 1'b0);
            run_op(2000, -1);
            n_vec++; if (st_done !== 1'b1) begin n_err++; $display("FAIL save_done: got %b expected 1", st_done); end
            n_vec++; if (st_cycles != 512) begin n_err++; $display("FAIL save_latency: got %0d expected 512", st_cycles); end
            n_vec++; if (st_mem_we != 128) begin n_err++; $display("FAIL save_mem_we_count: got %0d expected 128", st_mem_we); end
            n_vec++; if (st_we_pulses != 0) begin n_err++; $display("FAIL save_we_reg_count: got %0d expected 0", st_we_pulses); end
            n_vec++; if (st_err_at_done !== 1'b0) begin n_err++; $display("FAIL save_err: got %b expected 0", st_err_at_done); end
            n_vec++; if (st_bad != 0) begin n_err++; $display("FAIL save_busy_act: got %0d bad cycles expected 0", st_bad); end
            n_vec++; if (st_post !== 5'b0) begin n_err++; $display("FAIL save_after_done: got %b expected 00000", st_post); end
            if (it == 0) begin
                n_vec++; if (buffer[BUF_BASE + 0] !== 8'h5A) begin n_err++; $display("FAIL save_buf0: got %0h expected 5a", buffer[BUF_BASE + 0]); end
                n_vec++; if (buffer[BUF_BASE + 1] !== 8'h5B) begin n_err++; $display("FAIL save_buf1: got %0h expected 5b", buffer[BUF_BASE + 1]); end
                n_vec++; if (buffer[BUF_BASE + 127] !== 8'd87) begin n_err++; $display("FAIL save_buf127: got %0d expected 87", buffer[BUF_BASE + 127]); end
            end
            bad = 0;
            for (int i = 0; i < 128; i++) if (buffer[BUF_BASE + i] !== exp_img[i]) bad++;
            n_vec++; if (bad != 0) begin n_err++; $display("FAIL save_image: got %0d wrong bytes expected 0", bad); end
        end
    endtask

    task automatic test_load();
        int bad;
        logic [7:0] id;
        m2_run = 1'b1;
        repeat (30) @(posedge clk); #1;
        for (int it = 0; it < 2; it++) begin
            id = (it == 0) ? 8'd87 : 8'($urandom);
            for (int i = 0; i < 128; i++) begin
                mapper_regs[i] = 8'($urandom);
                buffer[BUF_BASE + i] = 8'($urandom);
                wr_cnt[i] = 0;
            end
            if (it == 0) begin buffer[BUF_BASE + 0] = 8'h02; mapper_regs[0] = 8'h00; end
            mapper_regs[127] = id;
            buffer[BUF_BASE + 127] = id;
            for (int i = 0; i < 127; i++) exp_img[i] = buffer[BUF_BASE + i];
            kick(1'b0, 1'b1);
            run_op(8000, -1);
            n_vec++; if (st_done !== 1'b1) begin n_err++; $display("FAIL load_done: got %b expected 1", st_done); end
            n_vec++; if (st_err_at_done !== 1'b0) begin n_err++; $display("FAIL load_err: got %b expected 0", st_err_at_done); end
            n_vec++; if (st_we_pulses != 127) begin n_err++; $display("FAIL load_we_reg_count: got %0d expected 127", st_we_pulses); end
            n_vec++; if (st_mem_we != 0) begin n_err++; $display("FAIL load_mem_we: got %0d expected 0", st_mem_we); end
            n_vec++; if (st_lat_bad != 0) begin n_err++; $display("FAIL load_m2_latency: got %0d bad drops expected 0", st_lat_bad); end
            n_vec++; if (wr_cnt[127] != 0) begin n_err++; $display("FAIL load_id_written: got %0d writes expected 0", wr_cnt[127]); end
            n_vec++; if (mapper_regs[127] !== id) begin n_err++; $display("FAIL load_id_reg: got %0h expected %0h", mapper_regs[127], id); end
            n_vec++; if (st_post !== 5'b0) begin n_err++; $display("FAIL load_after_done: got %b expected 00000", st_post); end
            if (it == 0) begin
                n_vec++; if (mapper_regs[0][1:0] !== 2'b10) begin n_err++; $display("FAIL load_chr_reg: got %b expected 10", mapper_regs[0][1:0]); end
            end
            bad = 0;
            for (int i = 0; i < 127; i++) if (mapper_regs[i] !== exp_img[i]) bad++;
            n_vec++; if (bad != 0) begin n_err++; $display("FAIL load_image: got %0d wrong regs expected 0", bad); end
        end
    endtask

    task automatic test_id_mismatch();
        int bad;
        for (int i = 0; i < 128; i++) begin
            mapper_regs[i] = 8'($urandom);
            buffer[BUF_BASE + i] = 8'($urandom);
            wr_cnt[i] = 0;
        end
        mapper_regs[127] = 8'd87;
        buffer[BUF_BASE + 127] = 8'd66;
        for (int i = 0; i < 128; i++) exp_img[i] = mapper_regs[i];
        kick(1'b0, 1'b1);
        run_op(200, -1);
        n_vec++; if (st_done !== 1'b1) begin n_err++; $display("FAIL idchk_done: got %b expected 1", st_done); end
        n_vec++; if (st_err_at_done !== 1'b1) begin n_err++; $display("FAIL idchk_err: got %b expected 1", st_err_at_done); end
        n_vec++; if (st_we_pulses != 0) begin n_err++; $display("FAIL idchk_we_reg_count: got %0d expected 0", st_we_pulses); end
        n_vec++; if (st_post[2] !== 1'b0) begin n_err++; $display("FAIL idchk_act_after_done: got %b expected 0", st_post[2]); end
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL idchk_err_sticky: got %b expected 1", err); end
        bad = 0;
        for (int i = 0; i < 128; i++) if (mapper_regs[i] !== exp_img[i]) bad++;
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL idchk_regs_touched: got %0d changed expected 0", bad); end
    endtask

    task automatic test_timeout();
        m2_run = 1'b0;
        repeat (20) @(posedge clk); #1;
        for (int i = 0; i < 128; i++) begin buffer[BUF_BASE + i] = 8'($urandom); wr_cnt[i] = 0; end
        mapper_regs[127] = 8'($urandom);
        buffer[BUF_BASE + 127] = mapper_regs[127];
        kick(1'b0, 1'b1);
        run_op(3000, -1);
        n_vec++; if (st_done !== 1'b1) begin n_err++; $display("FAIL tmo_done: got %b expected 1", st_done); end
        n_vec++; if (st_err_at_done !== 1'b1) begin n_err++; $display("FAIL tmo_err: got %b expected 1", st_err_at_done); end
        n_vec++; if (st_we_at_done !== 1'b0) begin n_err++; $display("FAIL tmo_we_reg: got %b expected 0", st_we_at_done); end
        n_vec++; if (st_we_hi != 1025) begin n_err++; $display("FAIL tmo_hold_cycles: got %0d expected 1025", st_we_hi); end
        n_vec++; if (st_addr_at_done !== 8'h00) begin n_err++; $display("FAIL tmo_addr: got %0h expected 0", st_addr_at_done); end
        n_vec++; if (wr_cnt[0] != 0) begin n_err++; $display("FAIL tmo_latched: got %0d writes expected 0", wr_cnt[0]); end
        n_vec++; if (st_post !== 5'b0) begin n_err++; $display("FAIL tmo_after_done: got %b expected 00000", st_post); end
    endtask

    task automatic test_both_starts();
        int bad, busy_seen;
        for (int i = 0; i < 128; i++) begin
            mapper_regs[i] = 8'($urandom);
            buffer[BUF_BASE + i] = 8'hFF;
            exp_img[i] = mapper_regs[i];
        end
        kick(1'b1, 1'b1);
        run_op(2000, 100);
        n_vec++; if (st_done !== 1'b1) begin n_err++; $display("FAIL both_done: got %b expected 1", st_done); end
        n_vec++; if (st_cycles != 512) begin n_err++; $display("FAIL both_latency: got %0d expected 512", st_cycles); end
        n_vec++; if (st_mem_we != 128) begin n_err++; $display("FAIL both_mem_we_count: got %0d expected 128", st_mem_we); end
        n_vec++; if (st_we_pulses != 0) begin n_err++; $display("FAIL both_we_reg_count: got %0d expected 0", st_we_pulses); end
        n_vec++; if (st_err_at_done !== 1'b0) begin n_err++; $display("FAIL both_err_cleared: got %b expected 0", st_err_at_done); end
        bad = 0;
        for (int i = 0; i < 128; i++) if (buffer[BUF_BASE + i] !== exp_img[i]) bad++;
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL both_image: got %0d wrong bytes expected 0", bad); end
        busy_seen = 0;
        repeat (6) begin @(posedge clk); #1; if (busy !== 1'b0) busy_seen++; end
        n_vec++; if (busy_seen != 0) begin n_err++; $display("FAIL both_late_load: got %0d busy cycles expected 0", busy_seen); end
    endtask

    task automatic test_reset_mid_save();
        int  c, bad, done_seen;
        bit  hit;
        for (int i = 0; i < 128; i++) mapper_regs[i] = 8'($urandom);
        kick(1'b1, 1'b0);
        hit = 0;
        for (c = 0; c < 400; c++) begin
            if (sst_addr === 8'd40) begin hit = 1; break; end
            @(posedge clk); #1;
        end
        n_vec++; if (hit !== 1'b1) begin n_err++; $display("FAIL rst_reach_idx40: got %b expected 1", hit); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_vec++; if ({busy, done, err, sst_act, sst_we_reg, mem_we} !== 6'b0) begin n_err++;
            $display("FAIL rst_mid_flags: got %b expected 000000", {busy, done, err, sst_act, sst_we_reg, mem_we}); end
        n_vec++; if ({sst_addr, sst_dato, mem_dout, mem_addr} !== 40'h0) begin n_err++;
            $display("FAIL rst_mid_buses: got %0h expected 0", {sst_addr, sst_dato, mem_dout, mem_addr}); end
        rst_n = 1'b1;
        done_seen = 0;
        repeat (10) begin @(posedge clk); #1; if (done !== 1'b0 || busy !== 1'b0) done_seen++; end
        n_vec++; if (done_seen != 0) begin n_err++; $display("FAIL rst_no_done: got %0d active cycles expected 0", done_seen); end
        for (int i = 0; i < 128; i++) begin
            mapper_regs[i] = 8'($urandom);
            buffer[BUF_BASE + i] = 8'hEE;
            exp_img[i] = mapper_regs[i];
        end
        kick(1'b1, 1'b0);
        run_op(2000, -1);
        n_vec++; if (st_done !== 1'b1 || st_cycles != 512) begin n_err++;
            $display("FAIL rst_resave_latency: got done=%b cycles=%0d expected done=1 cycles=512", st_done, st_cycles); end
        bad = 0;
        for (int i = 0; i < 128; i++) if (buffer[BUF_BASE + i] !== exp_img[i]) bad++;
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL rst_resave_image: got %0d wrong bytes expected 0", bad); end
    endtask

    initial begin
        last_fall = 0;
        test_reset();
        test_save();
        test_load();
        test_id_mismatch();
        test_timeout();
        test_both_starts();
        test_reset_mid_save();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
